// File: rtl/aes_pkg.sv
//==============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 constants, types, forward S-box and rcon lookup.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package aes_pkg;

    localparam int AES_NK = 4;
    localparam int AES_NR = 10;

    typedef logic [31:0] word_t;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    // Byte n of the forward S-box lives at bits [8n +: 8] (big-endian range).
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sub_word.sv
//==============================================================================
// Module      : aes_sub_word
// Description : 32-bit SubWord, four parallel forward S-box lookups.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module aes_sub_word
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign word_o[8*gi +: 8] = sbox(word_i[8*gi +: 8]);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/aes_key_expand.sv
//==============================================================================
// Module      : aes_key_expand
// Description : Iterative AES-128 key schedule, one round key per cycle.
//               Optional round-key store enabled by macro AES_KEY_STORE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module aes_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] round_key,
    output logic         round_key_valid,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
`ifdef AES_KEY_STORE_EN
    ,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
`endif
);

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [127:0] wr_key;

    word_t w_rot, w_sub, w_t, w_n0, w_n1, w_n2, w_n3;

    assign w_rot = {key_q[23:0], key_q[31:24]};

    aes_sub_word u_sub_word (
        .word_i (w_rot),
        .word_o (w_sub)
    );

    assign w_t  = w_sub ^ {rcon(idx_q + 4'd1), 24'h0};
    assign w_n0 = key_q[127:96] ^ w_t;
    assign w_n1 = key_q[95:64]  ^ w_n0;
    assign w_n2 = key_q[63:32]  ^ w_n1;
    assign w_n3 = key_q[31:0]   ^ w_n2;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = 4'd0;
        wr_key  = key_in;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    key_d   = key_in;
                    idx_d   = 4'd0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    wr_en   = 1'b1;
                end
            end
            default: begin
                if (idx_q == 4'(AES_NR)) begin
                    // Round 10 has been presented; key and index hold their values.
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    key_d   = {w_n0, w_n1, w_n2, w_n3};
                    idx_d   = idx_q + 4'd1;
                    done_d  = (idx_q == 4'(AES_NR - 1));
                    wr_en   = 1'b1;
                    wr_idx  = idx_q + 4'd1;
                    wr_key  = {w_n0, w_n1, w_n2, w_n3};
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign round_key       = key_q;
    assign round_idx       = idx_q;
    assign round_key_valid = valid_q;
    assign busy            = busy_q;
    assign done            = done_q;

`ifdef AES_KEY_STORE_EN
    logic [127:0] store_q [0:AES_NR];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= AES_NR; i++) begin
                store_q[i] <= '0;
            end
        end else if (wr_en) begin
            store_q[wr_idx] <= wr_key;
        end
    end

    assign rd_key = (rd_idx <= 4'(AES_NR)) ? store_q[rd_idx] : '0;
`else
    logic w_unused;
    assign w_unused = &{1'b0, wr_en, wr_idx, wr_key};
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expand.sv
//==============================================================================
// Module      : tb_aes_key_expand
// Description : Directed, table-driven checks of the AES-128 key expander.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic [127:0] round_key;
    logic         round_key_valid;
    logic [3:0]   round_idx;
    logic         busy;
    logic         done;
`ifdef AES_KEY_STORE_EN
    logic [3:0]   rd_idx = 4'd0;
    logic [127:0] rd_key;
`endif

    aes_key_expand dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .key_in          (key_in),
        .round_key       (round_key),
        .round_key_valid (round_key_valid),
        .round_idx       (round_idx),
        .busy            (busy),
        .done            (done)
`ifdef AES_KEY_STORE_EN
        ,
        .rd_idx          (rd_idx),
        .rd_key          (rd_key)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;

    logic [127:0] a1 [0:10];
    logic [127:0] cap [0:10];
    vec_t         tbl [13];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic start_key(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
        key_in = ~k;
    endtask

    // Records one run into cap[]; optionally re-pulses start after idx repulse_at.
    task automatic collect(input int repulse_at);
        int n = 0;
        check("round0_latency", {127'd0, round_key_valid}, 128'd1);
        for (int c = 0; c < 20; c++) begin
            if (!round_key_valid) break;
            check("idx_seq", {124'd0, round_idx}, 128'(n));
            check("done_pulse", {127'd0, done}, {127'd0, (n == 10)});
            check("busy_in_run", {127'd0, busy}, 128'd1);
            if (round_idx <= 4'd10) cap[round_idx] = round_key;
            n++;
            if (n - 1 == repulse_at) begin
                start  = 1'b1;
                key_in = KEY_ZERO;
            end else begin
                start  = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("valid_count", 128'(n), 128'd11);
        check("idle_busy", {127'd0, busy}, 128'd0);
        check("idle_done", {127'd0, done}, 128'd0);
        check("idle_idx_hold", {124'd0, round_idx}, 128'd10);
    endtask

    initial begin
        a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i < 11; i++) tbl[i] = '{KEY_A1, i, a1[i]};
        tbl[11] = '{KEY_ZERO, 1,  128'h62636363626363636263636362636363};
        tbl[12] = '{KEY_ZERO, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        #2;
        check("rst_key",   round_key, 128'd0);
        check("rst_valid", {127'd0, round_key_valid}, 128'd0);
        check("rst_idx",   {124'd0, round_idx}, 128'd0);
        check("rst_busy",  {127'd0, busy}, 128'd0);
        check("rst_done",  {127'd0, done}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Runs are chained: each start lands in the first IDLE cycle of the previous run.
        for (int v = 0; v < 13; v++) begin
            start_key(tbl[v].key);
            collect(-1);
            check($sformatf("vec%0d_idx%0d", v, tbl[v].idx), cap[tbl[v].idx], tbl[v].exp);
        end

        start_key(KEY_A1);
        collect(4);
        for (int i = 0; i < 11; i++) check($sformatf("repulse_idx%0d", i), cap[i], a1[i]);
        check("hold_round10", round_key, a1[10]);
        check("no_restart", {127'd0, round_key_valid}, 128'd0);

`ifdef AES_KEY_STORE_EN
        rd_idx = 4'd10; #1 check("store_rd10", rd_key, a1[10]);
        rd_idx = 4'd0;  #1 check("store_rd0",  rd_key, a1[0]);
        rd_idx = 4'd5;  #1 check("store_rd5",  rd_key, a1[5]);
        rd_idx = 4'd15; #1 check("store_rd15", rd_key, 128'd0);
        @(negedge clk);
`endif

        start_key(KEY_A1);
        begin
            int c = 0;
            while (round_idx != 4'd6 && c < 20) begin
                @(negedge clk);
                c++;
            end
            check("reach_idx6", {127'd0, (round_idx == 4'd6)}, 128'd1);
        end
        rst = 1'b1;
        #1;
        check("abort_key",   round_key, 128'd0);
        check("abort_valid", {127'd0, round_key_valid}, 128'd0);
        check("abort_idx",   {124'd0, round_idx}, 128'd0);
        check("abort_busy",  {127'd0, busy}, 128'd0);
        check("abort_done",  {127'd0, done}, 128'd0);
`ifdef AES_KEY_STORE_EN
        rd_idx = 4'd0; #1 check("abort_store", rd_key, 128'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_key(KEY_A1);
        check("restart_idx0_key", round_key, KEY_A1);
        collect(-1);
        check("restart_idx10", cap[10], a1[10]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
